voice_allocator: RTL
====================

Name: voice_allocator

Overview:
Schedules incoming note commands from the Avalon slave onto the 16 generator banks inside bank_manager, so the banks are shared among an unbounded stream of notes. It sits between the host write register and the bank_manager command input. It tracks which bank plays which note, retriggers repeated notes, frees banks when their release completes, and steals the oldest bank when all are busy. Its output names the target bank explicitly, so bank_manager no longer chooses a bank itself.

Parameters:
NUM_VOICES, 16, number of generator banks; must be a power of two, at most 16.
AGE_W, 8, width of the per-voice saturating age counter.

Ports:
clk  in  1  system clock.
n_rst  in  1  reset; asynchronous, active-low.
i_cmd_valid  in  1  host command present.
i_cmd  in  16  command: [15] on/off (1 = on), [14:8] note, [7:0] velocity.
o_cmd_ready  out  1  allocator can accept a command.
o_bank_valid  out  1  bank command valid.
o_bank_idx  out  4  target bank.
o_bank_cmd  out  16  command forwarded to the bank, same format as i_cmd.
i_bank_ready  in  1  bank_manager accepts the bank command.
i_voice_done  in  1  a bank finished its release phase.
i_voice_done_idx  in  4  bank that finished.
o_active_count  out  5  number of voices not FREE.

Behaviour:
- Reset (n_rst low, asynchronous): every voice FREE, all ages 0, FSM in IDLE, o_cmd_ready=0, o_bank_valid=0, o_bank_idx=0, o_bank_cmd=0, o_active_count=0. A command in flight is discarded.
- After reset is released, o_cmd_ready=1 in IDLE only.
- Per-voice state: FREE, HELD, RELEASING; plus a 7-bit note and an AGE_W-bit age.
- A note-on with velocity 0 is treated as a note-off.
- FSM states:
  - IDLE: when i_cmd_valid & o_cmd_ready, latch i_cmd and go to SCAN.
  - SCAN: examine one voice per cycle, index 0..NUM_VOICES-1, so NUM_VOICES cycles. Track these candidates:
    - matching note (HELD or RELEASING);
    - lowest-index FREE voice;
    - oldest RELEASING voice;
    - oldest HELD voice.
    - Oldest means largest age; ties go to the lower index.
  - DECIDE (1 cycle):
    - Note-on target priority: matching note (retrigger), then FREE, then oldest RELEASING, then oldest HELD (steal). The target becomes HELD with the new note and age 0. Every other non-FREE voice's age increments, saturating at 2^AGE_W-1.
    - Note-off: the target is the HELD voice with the matching note, which becomes RELEASING. If there is no match, the command is dropped and the FSM returns to IDLE with no output.
  - ISSUE: o_bank_valid=1, o_bank_idx=target, o_bank_cmd=latched command (velocity-0 on rewritten with [15]=0). Hold all outputs stable until i_bank_ready, then go to IDLE.
- Latency: command accepted at cycle 0 → o_bank_valid first high at cycle NUM_VOICES+2.
- i_voice_done handling:
  - Sampled every cycle in every state. It sets the indexed voice FREE only if that voice is RELEASING; otherwise it is ignored.
  - If it names the voice chosen in the same DECIDE cycle, the allocation wins and the voice is HELD.
  - If it frees a voice already passed during SCAN, that voice is not reconsidered for the current command.
- o_active_count is registered and updated the cycle after any state change. Range 0..NUM_VOICES.
- Indices ≥ NUM_VOICES on i_voice_done_idx are ignored.

Decomposition:
- synth_pkg holds:
  - command field positions (ON bit 15, NOTE 14:8, VEL 7:0);
  - voice-state encoding (FREE=2'd0, HELD=2'd1, RELEASING=2'd2);
  - the FSM state encoding;
  - the NUM_VOICES default.
- One sub-module, voice_table: holds the state/note/age arrays. It provides a single read port for SCAN and a write port used by DECIDE and i_voice_done, applying the priority rule above.
- Scan logic and the FSM stay in voice_allocator.

Test Plan:
- After reset, note-on 0x_C540 (note 0x45, vel 0x40) → o_bank_valid at cycle 18, o_bank_idx=0, o_bank_cmd=0xC540, o_active_count=1.
- Note-on note 0x45 again while HELD → same idx 0 (retrigger), o_active_count stays 1. Then note-on 0x28 → idx 1.
- Note-off 0x45 (0x4500) → idx 0, cmd 0x4500. Note-off for an unplayed note 0x30 → no o_bank_valid; o_cmd_ready returns high 18 cycles after accept.
- Fill all 16 voices with notes 0x10..0x1F, then note-on 0x20 → steals idx 0 (oldest HELD), o_active_count=16. Repeat with voice 5 RELEASING → steals idx 5.
- Voice 3 RELEASING, then i_voice_done_idx=3 → o_active_count decrements next cycle. A subsequent note-on takes idx 3 if it is the lowest FREE voice. A done pulse for a HELD voice changes nothing.
- Hold i_bank_ready=0 for 10 cycles during ISSUE → outputs stable, o_cmd_ready=0. Assert n_rst low mid-SCAN → all outputs 0 immediately and the table is cleared.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared definitions for the voice allocator: command field layout, per-voice
// state encoding and allocator FSM encoding.
package synth_pkg;

  localparam int NUM_VOICES_DEF = 16;
  localparam int AGE_W_DEF      = 8;

  localparam int CMD_ON  = 15;
  localparam int NOTE_HI = 14;
  localparam int NOTE_LO = 8;
  localparam int VEL_HI  = 7;
  localparam int VEL_LO  = 0;

  typedef enum logic [1:0] {
    V_FREE      = 2'd0,
    V_HELD      = 2'd1,
    V_RELEASING = 2'd2
  } voice_state_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_DECIDE = 2'd2,
    S_ISSUE  = 2'd3
  } fsm_state_e;

  // A note-on carrying velocity 0 behaves as a note-off.
  function automatic logic cmd_is_on(input logic [15:0] cmd);
    return cmd[CMD_ON] && (cmd[VEL_HI:VEL_LO] != 8'd0);
  endfunction

endpackage

// File: rtl/voice_table.sv
// Per-voice state/note/age storage with one scan read port and one allocation
// write port; an allocation to a voice wins over a same-cycle release-done.
module voice_table
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int AGE_W      = AGE_W_DEF,
  parameter int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [1:0]            rd_state,
  output logic [6:0]            rd_note,
  output logic [AGE_W-1:0]      rd_age,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic                  wr_on,
  input  logic [6:0]            wr_note,
  input  logic                  done_valid,
  input  logic [3:0]            done_idx,
  output logic [NUM_VOICES-1:0] busy
);

  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  voice_state_e     vstate [NUM_VOICES];
  logic [6:0]       vnote  [NUM_VOICES];
  logic [AGE_W-1:0] vage   [NUM_VOICES];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        vstate[v] <= V_FREE;
        vnote[v]  <= '0;
        vage[v]   <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (wr_en && (wr_idx == IDX_W'(v))) begin
          if (wr_on) begin
            vstate[v] <= V_HELD;
            vnote[v]  <= wr_note;
            vage[v]   <= '0;
          end else begin
            vstate[v] <= V_RELEASING;
          end
        end else if (done_valid && (done_idx == 4'(v)) && (vstate[v] == V_RELEASING)) begin
          vstate[v] <= V_FREE;
          vage[v]   <= '0;
        end else if (wr_en && wr_on && (vstate[v] != V_FREE) && (vage[v] != AGE_MAX)) begin
          vage[v] <= vage[v] + AGE_W'(1);
        end
      end
    end
  end

  assign rd_state = vstate[rd_idx];
  assign rd_note  = vnote[rd_idx];
  assign rd_age   = vage[rd_idx];

  always_comb begin
    busy = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      busy[v] = (vstate[v] != V_FREE);
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Maps host note commands onto generator banks: retrigger, free-voice reuse,
// and oldest-voice stealing, chosen by a sequential scan of the voice table.
//
// state  | meaning
// IDLE   | ready for a host command
// SCAN   | visit one voice per cycle, collect candidates
// DECIDE | pick target, update the voice table
// ISSUE  | present bank command until bank_manager accepts it
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int AGE_W      = AGE_W_DEF
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_cmd_valid,
  input  logic [15:0] i_cmd,
  output logic        o_cmd_ready,
  output logic        o_bank_valid,
  output logic [3:0]  o_bank_idx,
  output logic [15:0] o_bank_cmd,
  input  logic        i_bank_ready,
  input  logic        i_voice_done,
  input  logic [3:0]  i_voice_done_idx,
  output logic [4:0]  o_active_count
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  fsm_state_e       state_q, state_d;
  logic [15:0]      cmd_q;
  logic [IDX_W-1:0] scan_idx_q;

  logic             match_vld_q, hmatch_vld_q, free_vld_q, rel_vld_q, held_vld_q;
  logic [IDX_W-1:0] match_idx_q, hmatch_idx_q, free_idx_q, rel_idx_q, held_idx_q;
  logic [AGE_W-1:0] rel_age_q, held_age_q;

  logic [1:0]            rd_state;
  logic [6:0]            rd_note;
  logic [AGE_W-1:0]      rd_age;
  logic [NUM_VOICES-1:0] busy;

  logic             cmd_on;
  logic [6:0]       cmd_note;
  logic             accept;
  logic             decide_hit;
  logic [IDX_W-1:0] target_idx;
  logic             wr_en;
  logic [4:0]       active_d;

  assign cmd_on   = cmd_is_on(cmd_q);
  assign cmd_note = cmd_q[NOTE_HI:NOTE_LO];
  assign accept   = (state_q == S_IDLE) && i_cmd_valid && o_cmd_ready;
  assign wr_en    = (state_q == S_DECIDE) && decide_hit;

  voice_table #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W),
    .IDX_W      (IDX_W)
  ) u_voice_table (
    .clk        (clk),
    .n_rst      (n_rst),
    .rd_idx     (scan_idx_q),
    .rd_state   (rd_state),
    .rd_note    (rd_note),
    .rd_age     (rd_age),
    .wr_en      (wr_en),
    .wr_idx     (target_idx),
    .wr_on      (cmd_on),
    .wr_note    (cmd_note),
    .done_valid (i_voice_done),
    .done_idx   (i_voice_done_idx),
    .busy       (busy)
  );

  // Note-on priority: retrigger, free, oldest releasing, oldest held.
  always_comb begin
    decide_hit = 1'b0;
    target_idx = '0;
    if (cmd_on) begin
      decide_hit = 1'b1;
      if (match_vld_q)       target_idx = match_idx_q;
      else if (free_vld_q)   target_idx = free_idx_q;
      else if (rel_vld_q)    target_idx = rel_idx_q;
      else if (held_vld_q)   target_idx = held_idx_q;
      else                   decide_hit = 1'b0;
    end else if (hmatch_vld_q) begin
      decide_hit = 1'b1;
      target_idx = hmatch_idx_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_SCAN;
      S_SCAN:   if (scan_idx_q == IDX_W'(NUM_VOICES - 1)) state_d = S_DECIDE;
      S_DECIDE: state_d = decide_hit ? S_ISSUE : S_IDLE;
      S_ISSUE:  if (i_bank_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_cmd_ready  <= 1'b0;
      o_bank_valid <= 1'b0;
      o_bank_idx   <= '0;
      o_bank_cmd   <= '0;
    end else begin
      o_cmd_ready  <= (state_d == S_IDLE);
      o_bank_valid <= (state_d == S_ISSUE);
      if (wr_en) begin
        o_bank_idx <= 4'(target_idx);
        o_bank_cmd <= {cmd_on, cmd_q[14:0]};
      end
    end
  end

  // Strict '>' on age keeps the lower index on ties since voices are visited in order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cmd_q        <= '0;
      scan_idx_q   <= '0;
      match_vld_q  <= 1'b0;
      hmatch_vld_q <= 1'b0;
      free_vld_q   <= 1'b0;
      rel_vld_q    <= 1'b0;
      held_vld_q   <= 1'b0;
      match_idx_q  <= '0;
      hmatch_idx_q <= '0;
      free_idx_q   <= '0;
      rel_idx_q    <= '0;
      held_idx_q   <= '0;
      rel_age_q    <= '0;
      held_age_q   <= '0;
    end else if (accept) begin
      cmd_q        <= i_cmd;
      scan_idx_q   <= '0;
      match_vld_q  <= 1'b0;
      hmatch_vld_q <= 1'b0;
      free_vld_q   <= 1'b0;
      rel_vld_q    <= 1'b0;
      held_vld_q   <= 1'b0;
    end else if (state_q == S_SCAN) begin
      scan_idx_q <= scan_idx_q + IDX_W'(1);
      if ((rd_state != V_FREE) && (rd_note == cmd_note) && !match_vld_q) begin
        match_vld_q <= 1'b1;
        match_idx_q <= scan_idx_q;
      end
      if ((rd_state == V_HELD) && (rd_note == cmd_note) && !hmatch_vld_q) begin
        hmatch_vld_q <= 1'b1;
        hmatch_idx_q <= scan_idx_q;
      end
      if ((rd_state == V_FREE) && !free_vld_q) begin
        free_vld_q <= 1'b1;
        free_idx_q <= scan_idx_q;
      end
      if ((rd_state == V_RELEASING) && (!rel_vld_q || (rd_age > rel_age_q))) begin
        rel_vld_q <= 1'b1;
        rel_idx_q <= scan_idx_q;
        rel_age_q <= rd_age;
      end
      if ((rd_state == V_HELD) && (!held_vld_q || (rd_age > held_age_q))) begin
        held_vld_q <= 1'b1;
        held_idx_q <= scan_idx_q;
        held_age_q <= rd_age;
      end
    end
  end

  always_comb begin
    active_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      active_d = active_d + 5'(busy[v]);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) o_active_count <= '0;
    else        o_active_count <= active_d;
  end

endmodule
